// File: rtl/gear_display_if.sv
// Indicator bus between the transmission FSM (master) and the gear display decoder (slave).
// Carries the one-hot gear lamps, the 2-bit state code and the decoded display outputs.
interface gear_display_if #(
    parameter int CNT_W = 8
);
    logic             P1, N1, R1;
    logic             D1, D2, D3, D4;
    logic             M1, M0;
    logic [2:0]       gear_code;
    logic [6:0]       seg;
    logic             dp;
    logic             fault;
    logic             shift_pulse;
    logic [CNT_W-1:0] shift_count;

    modport master (
        output P1, N1, R1, D1, D2, D3, D4, M1, M0,
        input  gear_code, seg, dp, fault, shift_pulse, shift_count
    );

    modport slave (
        input  P1, N1, R1, D1, D2, D3, D4, M1, M0,
        output gear_code, seg, dp, fault, shift_pulse, shift_count
    );
endinterface

// File: rtl/gear_display_decoder.sv
// Gear indicator decoder: registers lamps/state code, filters disagreements through an
// OK/SUSPECT/FAULT checker, holds the last valid gear and drives a 7-segment display.
module gear_display_decoder #(
    parameter int FAULT_CYC = 3,
    parameter int BLINK_DIV = 8,
    parameter int CNT_W     = 8
) (
    input logic          clk,
    input logic          reset_n,
    gear_display_if.slave bus
);
    localparam int RUN_W = $clog2(FAULT_CYC + 1);
    localparam int BLK_W = $clog2(2 * BLINK_DIV);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FAULT_CYC - 1);
    localparam logic [BLK_W-1:0] BLK_HALF = BLK_W'(BLINK_DIV);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(2 * BLINK_DIV - 1);
    localparam logic [2:0]       GEAR_FAULT = 3'd7;

    typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULT} state_t;

    function automatic logic is_drive(input logic [2:0] g);
        return (g >= 3'd3) && (g <= 3'd6);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [6:0] seg_of(input logic [2:0] g);
        case (g)
            3'd0:    return 7'h73;
            3'd1:    return 7'h54;
            3'd2:    return 7'h50;
            3'd3:    return 7'h06;
            3'd4:    return 7'h5B;
            3'd5:    return 7'h4F;
            3'd6:    return 7'h66;
            default: return 7'h00;
        endcase
    endfunction

    logic [6:0]       lamp_p0;   // {D4,D3,D2,D1,R1,N1,P1}
    logic [1:0]       code_p0;
    logic [2:0]       dec_p0;
    logic [1:0]       grp_p0;
    logic             onehot_p0;
    logic             vld_p0;

    state_t           state_p1;
    logic [RUN_W-1:0] run_p1;
    logic [BLK_W-1:0] blink_p1;
    logic [2:0]       held_p1;
    logic             pulse_p1;
    logic [CNT_W-1:0] count_p1;
    logic             load_held;
    logic             changed;
    logic [2:0]       gear_code;

    // Stage p0: input register (resets to a valid P indication)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lamp_p0 <= 7'b0000001;
            code_p0 <= 2'b00;
        end else begin
            lamp_p0 <= {bus.D4, bus.D3, bus.D2, bus.D1, bus.R1, bus.N1, bus.P1};
            code_p0 <= {bus.M1, bus.M0};
        end
    end

    always_comb begin
        dec_p0    = 3'd0;
        grp_p0    = 2'd0;
        onehot_p0 = 1'b1;
        case (lamp_p0)
            7'b0000001: begin dec_p0 = 3'd0; grp_p0 = 2'd0; end
            7'b0000010: begin dec_p0 = 3'd1; grp_p0 = 2'd1; end
            7'b0000100: begin dec_p0 = 3'd2; grp_p0 = 2'd2; end
            7'b0001000: begin dec_p0 = 3'd3; grp_p0 = 2'd3; end
            7'b0010000: begin dec_p0 = 3'd4; grp_p0 = 2'd3; end
            7'b0100000: begin dec_p0 = 3'd5; grp_p0 = 2'd3; end
            7'b1000000: begin dec_p0 = 3'd6; grp_p0 = 2'd3; end
            default:    onehot_p0 = 1'b0;
        endcase
        vld_p0 = onehot_p0 && (code_p0 == grp_p0);
    end

    always_comb begin
        case (state_p1)
            ST_OK, ST_SUSPECT: load_held = vld_p0;
            ST_FAULT:          load_held = vld_p0 && (run_p1 == RUN_LAST);
            default:           load_held = 1'b0;
        endcase
        changed = load_held && (dec_p0 != held_p1);
    end

    // Stage p1: consistency checker, held gear and blink timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p1 <= ST_OK;
            run_p1   <= '0;
            blink_p1 <= '0;
        end else begin
            case (state_p1)
                ST_OK: begin
                    blink_p1 <= '0;
                    if (!vld_p0) begin
                        if (FAULT_CYC == 1) begin
                            state_p1 <= ST_FAULT;
                            run_p1   <= '0;
                        end else begin
                            state_p1 <= ST_SUSPECT;
                            run_p1   <= RUN_W'(1);
                        end
                    end
                end
                ST_SUSPECT: begin
                    blink_p1 <= '0;
                    if (vld_p0) begin
                        state_p1 <= ST_OK;
                        run_p1   <= '0;
                    end else if (run_p1 == RUN_LAST) begin
                        state_p1 <= ST_FAULT;
                        run_p1   <= '0;
                    end else begin
                        run_p1 <= run_p1 + RUN_W'(1);
                    end
                end
                ST_FAULT: begin
                    blink_p1 <= (blink_p1 == BLK_LAST) ? '0 : blink_p1 + BLK_W'(1);
                    if (!vld_p0) begin
                        run_p1 <= '0;
                    end else if (run_p1 == RUN_LAST) begin
                        state_p1 <= ST_OK;
                        run_p1   <= '0;
                        blink_p1 <= '0;
                    end else begin
                        run_p1 <= run_p1 + RUN_W'(1);
                    end
                end
                default: begin
                    state_p1 <= ST_OK;
                    run_p1   <= '0;
                    blink_p1 <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_p1  <= 3'd0;
            pulse_p1 <= 1'b0;
            count_p1 <= '0;
        end else begin
            if (load_held) held_p1 <= dec_p0;
            pulse_p1 <= changed;
            if (changed && is_drive(held_p1) && is_drive(dec_p0))
                count_p1 <= sat_inc(count_p1);
        end
    end

    always_comb begin
        gear_code = (state_p1 == ST_FAULT) ? GEAR_FAULT : held_p1;
        if (state_p1 == ST_FAULT)
            bus.seg = (blink_p1 < BLK_HALF) ? 7'h79 : 7'h00;
        else
            bus.seg = seg_of(held_p1);
    end

    assign bus.gear_code   = gear_code;
    assign bus.dp          = is_drive(gear_code);
    assign bus.fault       = (state_p1 == ST_FAULT);
    assign bus.shift_pulse = pulse_p1;
    assign bus.shift_count = count_p1;
endmodule
